// File: rtl/instruction_memory_sync_pkg.sv
// instruction_memory_sync shared definitions
// NOP fill pattern for words that were never written
package instruction_memory_sync_pkg;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   function automatic logic [7:0] nop_byte(
      input logic [1:0] idx
   );
      return NOP_WORD[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/instruction_memory_sync_byte_ram.sv
// Byte-lane array: multi-lane read, strobed write
// Unwritten words read as NOP; write-first bypass
module instruction_memory_sync_byte_ram
   import instruction_memory_sync_pkg::*;
#(
   parameter int MEM_SIZE = 65536,
   parameter int AW       = 16,
   parameter int FB       = 4,
   parameter int WB       = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rd_off,
   output logic [8*FB-1:0] rd_data,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_off,
   input  logic [8*WB-1:0] wr_data,
   input  logic [WB-1:0]   wr_strb
);

   localparam int NW = MEM_SIZE / 4;
   localparam int LW = $clog2(WB);

   logic [7:0]    mem [MEM_SIZE];
   logic [NW-1:0] vld_q;
   logic [NW-1:0] vld_d;
   logic [AW-1:0] wbase;
   logic [AW-1:0] wa [WB];
   logic [AW-1:0] ra [FB];
   logic [7:0]    wb [WB];
   logic [WB-1:0] we;
   logic          fill;

   assign wbase = wr_off & ~AW'(WB - 1);

   // Lane enables; first touch of a word fills
   // its unstrobed bytes with the NOP pattern
   always_comb begin
      vld_d = vld_q;
      wa    = '{default: '0};
      wb    = '{default: '0};
      we    = '0;
      fill  = 1'b0;
      for (int k = 0; k < WB; k++) begin
         wa[k] = wbase + AW'(k);
         fill  = wr_en
               & (|wr_strb[(k/4)*4 +: 4])
               & ~vld_q[wa[k][AW-1:2]];
         we[k] = (wr_en & wr_strb[k]) | fill;
         wb[k] = wr_strb[k]
               ? wr_data[8*k +: 8]
               : nop_byte(wa[k][1:0]);
         if (we[k])
            vld_d[wa[k][AW-1:2]] = 1'b1;
      end
   end

   // Word-valid map: cleared on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         vld_q <= '0;
      else
         vld_q <= vld_d;
   end

   // Byte storage update
   always_ff @(posedge clk) begin
      for (int k = 0; k < WB; k++) begin
         if (we[k])
            mem[wa[k]] <= wb[k];
      end
   end

   // Lane read with same-cycle write bypass
   always_comb begin
      rd_data = '0;
      ra      = '{default: '0};
      for (int i = 0; i < FB; i++) begin
         ra[i] = rd_off + AW'(i);
         if (vld_q[ra[i][AW-1:2]])
            rd_data[8*i +: 8] = mem[ra[i]];
         else
            rd_data[8*i +: 8] =
               nop_byte(ra[i][1:0]);
         if (ra[i][AW-1:LW] == wbase[AW-1:LW]
             && we[ra[i][LW-1:0]])
            rd_data[8*i +: 8] =
               wb[ra[i][LW-1:0]];
      end
   end

endmodule

// File: rtl/instruction_memory_sync.sv
// Instruction memory with fetch handshake
// Range check, flush and one response register
module instruction_memory_sync
   import instruction_memory_sync_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter int              FETCH_BYTES = 4,
   parameter int              MEM_SIZE    = 65536,
   parameter logic [XLEN-1:0] MEM_BASE    = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [XLEN-1:0]          req_addr,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [8*FETCH_BYTES-1:0] rsp_data,
   output logic                     rsp_fault,
   input  logic                     wr_en,
   input  logic [XLEN-1:0]          wr_addr,
   input  logic [XLEN-1:0]          wr_data,
   input  logic [XLEN/8-1:0]        wr_strb
);

   localparam int AW  = $clog2(MEM_SIZE);
   localparam int AW1 = AW + 1;
   localparam int FW  = 8 * FETCH_BYTES;

   if (FETCH_BYTES != 4 && FETCH_BYTES != 8)
   begin : g_bad_fetch
      $error("FETCH_BYTES must be 4 or 8");
   end
   if ((1 << AW) != MEM_SIZE)
   begin : g_bad_size
      $error("MEM_SIZE must be a power of two");
   end
   if (MEM_SIZE < 2 * FETCH_BYTES)
   begin : g_small_size
      $error("MEM_SIZE too small");
   end
   if (MEM_BASE[AW-1:0] != '0)
   begin : g_bad_base
      $error("MEM_BASE not MEM_SIZE aligned");
   end

   logic [XLEN-1:0] roff;
   logic [XLEN-1:0] woff;
   logic [AW:0]     rbase;
   logic [AW:0]     lane_off;
   logic            rfault;
   logic            winr;
   logic            accept;
   logic            unused_bit0;
   logic [FW-1:0]   ram_data;
   logic [FW-1:0]   fetch_data;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_fault_q, rsp_fault_d;
   logic [FW-1:0]   rsp_data_q,  rsp_data_d;

   assign roff   = req_addr - MEM_BASE;
   assign woff   = wr_addr - MEM_BASE;
   assign rfault = |roff[XLEN-1:AW];
   assign winr   = ~|woff[XLEN-1:AW];
   assign rbase  = {1'b0, roff[AW-1:1], 1'b0};
   assign unused_bit0 = roff[0];

   assign req_ready = ~rsp_valid_q | rsp_ready;
   assign accept    = req_valid & req_ready;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_fault = rsp_fault_q;

   instruction_memory_sync_byte_ram #(
      .MEM_SIZE (MEM_SIZE),
      .AW       (AW),
      .FB       (FETCH_BYTES),
      .WB       (XLEN / 8)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .rd_off  (rbase[AW-1:0]),
      .rd_data (ram_data),
      .wr_en   (wr_en & winr),
      .wr_off  (woff[AW-1:0]),
      .wr_data (wr_data),
      .wr_strb (wr_strb)
   );

   // Zero faulted fetches and bytes past the top
   always_comb begin
      fetch_data = '0;
      lane_off   = '0;
      for (int i = 0; i < FETCH_BYTES; i++) begin
         lane_off = rbase + AW1'(i);
         if (!rfault && !lane_off[AW])
            fetch_data[8*i +: 8] =
               ram_data[8*i +: 8];
      end
   end

   // Response register next state
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_fault_d = rsp_fault_q;
      rsp_data_d  = rsp_data_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_fault_d = rfault;
         rsp_data_d  = fetch_data;
      end else if (flush || rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // Response register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_fault_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_fault_q <= rsp_fault_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Bench for instruction_memory_sync
// Directed steps then random traffic vs model
module tb_instruction_memory_sync;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int          SIZE = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_fault;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;

   int total = 0;
   int bad   = 0;

   logic [7:0]  m [SIZE];
   logic        exp_valid;
   logic        exp_fault;
   logic [31:0] exp_data;

   instruction_memory_sync #(
      .XLEN        (32),
      .FETCH_BYTES (4),
      .MEM_SIZE    (SIZE),
      .MEM_BASE    (BASE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_fault (rsp_fault),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_strb   (wr_strb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [32:0] ref_fetch(
      input logic [31:0] a);
      logic [31:0] off;
      logic [31:0] d;
      off = (a - BASE) & ~32'd1;
      d   = '0;
      if (off >= SIZE) return {1'b1, 32'h0};
      for (int i = 0; i < 4; i++)
         if (off + i < SIZE)
            d[8*i +: 8] = m[off + i];
      return {1'b0, d};
   endfunction

   task automatic ref_write();
      logic [31:0] off;
      if (!wr_en) return;
      off = (wr_addr & ~32'd3) - BASE;
      if (off >= SIZE) return;
      for (int k = 0; k < 4; k++)
         if (wr_strb[k])
            m[off + k] = wr_data[8*k +: 8];
   endtask

   task automatic tick();
      logic rdy;
      rdy = !exp_valid || rsp_ready;
      #1;
      chk("req_ready", {31'b0, req_ready},
          {31'b0, rdy});
      @(posedge clk);
      ref_write();
      if (req_valid && rdy) begin
         {exp_fault, exp_data} =
            ref_fetch(req_addr);
         exp_valid = 1'b1;
      end else if (flush || rsp_ready) begin
         exp_valid = 1'b0;
      end
      #1;
      chk("rsp_valid", {31'b0, rsp_valid},
          {31'b0, exp_valid});
      if (exp_valid) begin
         chk("rsp_data", rsp_data, exp_data);
         chk("rsp_fault", {31'b0, rsp_fault},
             {31'b0, exp_fault});
      end
   endtask

   task automatic idle();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      flush     = 1'b0;
      wr_en     = 1'b0;
      wr_strb   = 4'h0;
   endtask

   task automatic fetch(input logic [31:0] a);
      req_valid = 1'b1;
      req_addr  = a;
   endtask

   task automatic wr(input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0]  s);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_strb = s;
   endtask

   initial begin
      for (int i = 0; i < SIZE; i++)
         m[i] = (i % 4 == 0) ? 8'h13 : 8'h00;
      exp_valid = 1'b0;
      exp_fault = 1'b0;
      exp_data  = '0;
      reset     = 1'b1;
      req_addr  = '0;
      wr_addr   = '0;
      wr_data   = '0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'b0, rsp_valid}, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_fault", {31'b0, rsp_fault}, 0);
      chk("rst_ready", {31'b0, req_ready}, 1);
      reset = 1'b0;

      // NOP image
      fetch(BASE);
      tick();
      chk("nop", rsp_data, 32'h0000_0013);
      idle();
      tick();

      // halfword-aligned fetch
      wr(BASE, 32'h0000_1137, 4'hF);
      tick();
      wr(BASE + 4, 32'h0000_0513, 4'h3);
      tick();
      idle();
      fetch(BASE + 2);
      tick();
      chk("half", rsp_data, 32'h0513_0000);
      idle();
      tick();

      // back-pressure with snapshot
      rsp_ready = 1'b0;
      fetch(BASE + 32'h10);
      tick();
      fetch(BASE + 32'h20);
      wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
      tick();
      wr_en = 1'b0;
      tick();
      tick();
      chk("held", rsp_data, 32'h0000_0013);
      rsp_ready = 1'b1;
      fetch(BASE + 32'h10);
      tick();
      chk("after", rsp_data, 32'hDEAD_BEEF);
      idle();
      tick();

      // write-first, partial strobe
      fetch(BASE + 32'h100);
      wr(BASE + 32'h100, 32'h0000_ABCD, 4'h3);
      tick();
      chk("wfirst", rsp_data, 32'h0000_ABCD);
      idle();

      // range edges, dropped write
      fetch(32'h7FFF_FFFC);
      tick();
      chk("below", {31'b0, rsp_fault}, 1);
      idle();
      wr(BASE + SIZE - 4, 32'hAABB_CCDD, 4'hF);
      tick();
      wr(BASE + SIZE, 32'h1234_5678, 4'hF);
      fetch(BASE + SIZE - 2);
      tick();
      chk("top", rsp_data, 32'h0000_AABB);
      idle();
      fetch(BASE + SIZE);
      tick();
      idle();
      tick();

      // flush without and with accept
      rsp_ready = 1'b0;
      fetch(BASE + 32'h40);
      tick();
      req_valid = 1'b0;
      flush     = 1'b1;
      tick();
      chk("flush0", {31'b0, rsp_valid}, 0);
      flush = 1'b0;
      fetch(BASE + 4);
      tick();
      flush     = 1'b1;
      rsp_ready = 1'b1;
      fetch(BASE);
      tick();
      chk("flush1", {31'b0, rsp_valid}, 1);
      idle();
      tick();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         rsp_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 7) == 0);
         req_addr  = BASE - 8 +
                     $urandom_range(0, SIZE + 15);
         wr_en     = ($urandom_range(0, 2) == 0);
         wr_addr   = BASE - 8 +
                     $urandom_range(0, SIZE + 15);
         wr_data   = $urandom;
         wr_strb   = 4'($urandom_range(0, 15));
         tick();
      end
      idle();
      tick();

      // reset while holding
      rsp_ready = 1'b0;
      fetch(BASE + 32'h80);
      tick();
      req_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("rst_hold", {31'b0, rsp_valid}, 0);
      @(posedge clk);
      #1;
      chk("rst_stay", {31'b0, rsp_valid}, 0);
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d",
               total, bad);
      $finish;
   end

endmodule
